// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache between CPU fetch and a 4-word-block memory.
// Latency: hit served combinationally in the request cycle; miss serves on cycle MEM_LATENCY+2.
// Backpressure: cpu_ready stays low during a line fill; the CPU holds cpu_read/cpu_address.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   cpu_read, cpu_address      fetch request (word address), held until cpu_ready
//   cpu_data, cpu_ready        fetched word (16'h0 unless ready), hit indication
//   flush                      invalidate all lines
//   mem_read, mem_address      line read strobe and line-aligned address (0 when idle)
//   mem_data                   line data, word at offset 0 in the top bits
//   hit_count, miss_count      saturating served-hit and fill-start counters
module icache_direct_mapped #(
   parameter int WORD_SIZE   = 16,
   parameter int LINE_WORDS  = 4,
   parameter int NUM_LINES   = 4,
   parameter int MEM_LATENCY = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            cpu_read,
   input  logic [15:0]                     cpu_address,
   output logic [WORD_SIZE-1:0]            cpu_data,
   output logic                            cpu_ready,
   input  logic                            flush,
   output logic                            mem_read,
   output logic [15:0]                     mem_address,
   input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_data,
   output logic [15:0]                     hit_count,
   output logic [15:0]                     miss_count
);

   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = 14 - IDX_W;
   localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
   localparam int LINE_W = LINE_WORDS * WORD_SIZE;

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t              state_q, state_d;
   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q  [NUM_LINES];
   logic [LINE_W-1:0]   data_q [NUM_LINES];
   logic [13:0]         fill_addr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                flush_pend_q;

   logic [1:0]          offset;
   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    tag;
   logic [IDX_W-1:0]    fill_idx;
   logic [TAG_W-1:0]    fill_tag;
   logic [LINE_W-1:0]   sel_line;
   logic                line_hit;
   logic                hit;
   logic                start_fill;
   logic                fill_done;

   assign offset   = cpu_address[1:0];
   assign idx      = cpu_address[2+IDX_W-1:2];
   assign tag      = cpu_address[15:2+IDX_W];
   assign fill_idx = fill_addr_q[IDX_W-1:0];
   assign fill_tag = fill_addr_q[13:IDX_W];
   assign sel_line = data_q[idx];
   assign line_hit = valid_q[idx] && (tag_q[idx] == tag);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state and outputs
   always_comb begin
      state_d     = state_q;
      start_fill  = 1'b0;
      fill_done   = 1'b0;
      hit         = 1'b0;
      cpu_ready   = 1'b0;
      cpu_data    = '0;
      mem_read    = 1'b0;
      mem_address = '0;
      case (state_q)
         S_IDLE: begin
            if (cpu_read && line_hit) begin
               hit       = 1'b1;
               cpu_ready = 1'b1;
               // offset 0 lives in the most significant word of the line
               cpu_data  = sel_line[(LINE_WORDS - 1 - int'(offset)) * WORD_SIZE +: WORD_SIZE];
            end else if (cpu_read) begin
               start_fill = 1'b1;
               state_d    = S_FILL;
            end
         end
         S_FILL: begin
            mem_read    = 1'b1;
            mem_address = {fill_addr_q, 2'b00};
            if (cnt_q == CNT_W'(MEM_LATENCY)) begin
               fill_done = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state, valid bits and counters
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         fill_addr_q  <= '0;
         hit_count    <= '0;
         miss_count   <= '0;
      end else begin
         if (start_fill) begin
            fill_addr_q <= cpu_address[15:2];
            cnt_q       <= '0;
         end else if (state_q == S_FILL) begin
            cnt_q <= cnt_q + 1'b1;
         end

         if (flush) valid_q <= '0;
         // A flush seen at any point of the fill (including its last cycle)
         // leaves the freshly written line invalid.
         if (fill_done) valid_q[fill_idx] <= ~(flush_pend_q | flush);

         if (fill_done)                        flush_pend_q <= 1'b0;
         else if (state_q == S_FILL && flush)  flush_pend_q <= 1'b1;

         if (hit && hit_count != 16'hFFFF)         hit_count  <= hit_count + 1'b1;
         if (start_fill && miss_count != 16'hFFFF) miss_count <= miss_count + 1'b1;
      end
   end

   // Line storage; a reset coinciding with the last fill cycle writes nothing
   always_ff @(posedge clk) begin
      if (!reset && fill_done) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= mem_data;
      end
   end

endmodule
